// File: rtl/gate_recorder_pkg.sv
// Shared definitions for the gate-loop recorder slice.
//   DEFAULT_DEBOUNCE : clk cycles a button must hold a new level before it is accepted
//   DEFAULT_STEPS    : default loop length in steps
//   pos_width()      : width of a step index for a given loop length
//   button_state_e   : debounced button level
//   `ACTIVE_LOW(sig) : turns an active-low board button into an active-high level
`ifndef GATE_RECORDER_PKG_SV
`define GATE_RECORDER_PKG_SV

`define ACTIVE_LOW(sig) (~(sig))

package gate_recorder_pkg;

    localparam int DEFAULT_DEBOUNCE = 65536;
    localparam int DEFAULT_STEPS    = 16;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } button_state_e;

    // A one-step loop still needs a 1-bit index, so never return zero.
    function automatic int pos_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

`endif

// File: rtl/gate_recorder_debounce.sv
// button_debounce: two-flop synchronizer, level debouncer and press pulse
// for one active-low asynchronous board button.
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   button_n : raw button, active-low, asynchronous
//   level    : debounced button level (1 = held)
//   press    : one-cycle pulse in the cycle the debounced level first reads held
module button_debounce
    import gate_recorder_pkg::*;
#(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic button_n,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync_a;
    logic             sync_b;
    logic             tap_level;
    button_state_e    debounced;
    logic [CNT_W-1:0] count;

    // Synchronizer resets to the idle (released) level so a reset never
    // looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= button_n;
            sync_b <= sync_a;
        end
    end

    assign tap_level = `ACTIVE_LOW(sync_b);

    // The counter measures how long the synchronized level has disagreed with
    // the accepted state; any agreement restarts it. The press pulse is
    // registered together with the state change so it lines up with level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            debounced <= RELEASED;
            count     <= '0;
            press     <= 1'b0;
        end else begin
            press <= 1'b0;
            if (tap_level == logic'(debounced)) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                debounced <= button_state_e'(tap_level);
                count     <= '0;
                press     <= tap_level;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign level = logic'(debounced);

endmodule

// File: rtl/gate_recorder.sv
// gate_recorder: captures live button taps, quantizes them to sequencer steps,
// stores them in a STEPS-bit loop pattern and plays the pattern back as a gate.
//   clk       : system clock
//   rst       : asynchronous reset, active-low
//   step_tick : one-cycle strobe per sequencer step
//   tap_n     : raw tap button, active-low, asynchronous
//   rec_en    : 1 = recording armed
//   overdub   : 1 = OR taps into the pattern, 0 = replace the step bit
//   clear_all : synchronous pulse that empties the pattern
//   length    : active loop length 1..STEPS (0 or >STEPS means STEPS)
//   gate_out  : pattern bit at the current step
//   step_pos  : current step index
//   step_wrap : one-cycle pulse when step_pos returns to 0
//   pattern   : full stored pattern
//   tap_seen  : debounced tap level
module gate_recorder
    import gate_recorder_pkg::*;
#(
    parameter int STEPS    = DEFAULT_STEPS,
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE,
    parameter int POS_W    = pos_width(STEPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_tick,
    input  logic             tap_n,
    input  logic             rec_en,
    input  logic             overdub,
    input  logic             clear_all,
    input  logic [POS_W:0]   length,
    output logic             gate_out,
    output logic [POS_W-1:0] step_pos,
    output logic             step_wrap,
    output logic [STEPS-1:0] pattern,
    output logic             tap_seen
);

    localparam logic [POS_W:0] STEPS_LEN = (POS_W + 1)'(STEPS);

    logic           press;
    logic           pending;
    logic [POS_W:0] eff_len;
    logic [POS_W:0] last_pos;
    logic           at_last;

    button_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_tap (
        .clk      (clk),
        .rst      (rst),
        .button_n (tap_n),
        .level    (tap_seen),
        .press    (press)
    );

    always_comb begin
        eff_len = length;
        if (length == '0 || length > STEPS_LEN) begin
            eff_len = STEPS_LEN;
        end
    end

    // ">=" rather than "==" so a loop shortened below the current step wraps
    // on the next tick instead of running on to the end of the register.
    assign last_pos = eff_len - 1'b1;
    assign at_last  = {1'b0, step_pos} >= last_pos;

    // A press landing on the same cycle as a tick belongs to the step being
    // entered, so the set wins over the tick's clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (press && rec_en) begin
            pending <= 1'b1;
        end else if (step_tick) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_pos  <= '0;
            step_wrap <= 1'b0;
        end else begin
            step_wrap <= step_tick && at_last;
            if (step_tick) begin
                step_pos <= at_last ? '0 : step_pos + 1'b1;
            end
        end
    end

    // The tick writes into the step being left, using pending as it stood
    // before the tick. clear_all overrides that write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= '0;
        end else if (clear_all) begin
            pattern <= '0;
        end else if (step_tick && rec_en) begin
            pattern[step_pos] <= overdub ? (pattern[step_pos] | pending) : pending;
        end
    end

    assign gate_out = pattern[step_pos];

endmodule

// File: tb/tb_gate_recorder.sv
// Testbench for gate_recorder (STEPS=16, DEBOUNCE=4). Expected responses for
// every step tick or clear are queued by the driver from a behavioural model
// and checked by an independent monitor one cycle later.
`timescale 1ns/1ps
module tb_gate_recorder;
    import gate_recorder_pkg::*;

    localparam int STEPS    = 16;
    localparam int DEB      = 4;
    localparam int POS_W    = 4;
    localparam int PERIOD   = 10;
    localparam int STEP_LEN = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             step_tick;
    logic             tap_n;
    logic             rec_en;
    logic             overdub;
    logic             clear_all;
    logic [POS_W:0]   length;
    logic             gate_out;
    logic [POS_W-1:0] step_pos;
    logic             step_wrap;
    logic [STEPS-1:0] pattern;
    logic             tap_seen;

    gate_recorder #(
        .STEPS    (STEPS),
        .DEBOUNCE (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step_tick (step_tick),
        .tap_n     (tap_n),
        .rec_en    (rec_en),
        .overdub   (overdub),
        .clear_all (clear_all),
        .length    (length),
        .gate_out  (gate_out),
        .step_pos  (step_pos),
        .step_wrap (step_wrap),
        .pattern   (pattern),
        .tap_seen  (tap_seen)
    );

    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        int               pos;
        bit               gate;
        bit               wrap;
        logic [STEPS-1:0] pat;
    } expect_t;

    expect_t exp_q[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      wrap_count = 0;

    // Reference model: the loop as an array of bits and a step counter.
    bit model_pat[STEPS];
    int model_pos;
    bit model_pending;

    // Tap schedule, in driver iterations. A tap held at least DEB cycles is
    // accepted 2+DEB cycles after the fall and released 2+DEB after the rise.
    int iter      = 0;
    int tap_start = -1000;
    int tap_len   = 0;
    bit tap_valid = 1'b0;

    function automatic int eff_len_of(input int len);
        return (len == 0 || len > STEPS) ? STEPS : len;
    endfunction

    function automatic logic [STEPS-1:0] pat_vec();
        logic [STEPS-1:0] v;
        for (int i = 0; i < STEPS; i++) v[i] = model_pat[i];
        return v;
    endfunction

    function automatic bit tap_low_at(input int j);
        return (j >= tap_start) && (j < tap_start + tap_len);
    endfunction

    function automatic bit press_at(input int j);
        return tap_valid && (j == tap_start + 2 + DEB);
    endfunction

    function automatic bit seen_at(input int j);
        return tap_valid && (j >= tap_start + 2 + DEB) && (j < tap_start + tap_len + 2 + DEB);
    endfunction

    function automatic bit tap_idle();
        return iter >= tap_start + tap_len + 2 + DEB + 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < STEPS; i++) model_pat[i] = 1'b0;
        model_pos     = 0;
        model_pending = 1'b0;
    endtask

    task automatic start_tap(input int len);
        tap_start = iter;
        tap_len   = len;
        tap_valid = (len >= DEB);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one clock cycle of inputs, advances the model by the same cycle,
    // queues the expected state after any tick or clear, and checks the
    // debounced tap level after the edge.
    task automatic applyStimulus(input bit tick, input bit clr);
        expect_t e;
        bit      press;
        int      eff;
        tap_n     = !tap_low_at(iter);
        step_tick = tick;
        clear_all = clr;
        press     = press_at(iter);
        eff       = eff_len_of(int'(length));
        e.wrap    = tick && (model_pos >= eff - 1);
        if (clr) begin
            for (int i = 0; i < STEPS; i++) model_pat[i] = 1'b0;
        end else if (tick && rec_en) begin
            model_pat[model_pos] = overdub ? (model_pat[model_pos] | model_pending) : model_pending;
        end
        if (tick) model_pos = e.wrap ? 0 : model_pos + 1;
        if (press && rec_en) model_pending = 1'b1;
        else if (tick)       model_pending = 1'b0;
        if (tick || clr) begin
            e.pos  = model_pos;
            e.gate = model_pat[model_pos];
            e.pat  = pat_vec();
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        iter++;
        checkOutput("tap_seen", 32'(tap_seen), 32'(seen_at(iter)));
    endtask

    // One sequencer step: optional tap at a given cycle, tick on the last cycle.
    task automatic do_step(input int tap_off, input int tap_l, input bit clr_on_tick);
        for (int c = 0; c < STEP_LEN; c++) begin
            if (c == tap_off) start_tap(tap_l);
            applyStimulus(c == STEP_LEN - 1, clr_on_tick && (c == STEP_LEN - 1));
        end
    endtask

    task automatic advance_to(input int target);
        int guard = 0;
        while (model_pos != target && guard < 64) begin
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
            guard++;
        end
    endtask

    task automatic fill_all();
        rec_en  = 1'b1;
        overdub = 1'b1;
        for (int s = 0; s < STEPS; s++) do_step(0, 4, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("fill_pattern", 32'(pattern), 32'h0000_FFFF);
    endtask

    // Monitor: whenever the DUT took a tick or clear, the next cycle must
    // match the oldest queued expectation.
    initial begin : monitor
        bit      fired;
        expect_t e;
        forever begin
            @(posedge clk);
            fired = step_tick || clear_all;
            @(negedge clk);
            if (fired && rst) begin
                if (exp_q.size() == 0) begin
                    mismatched++;
                    compared++;
                    $display("[TB] FAIL scoreboard_empty: got output with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("step_pos",  32'(step_pos),  32'(e.pos));
                    checkOutput("gate_out",  32'(gate_out),  32'(e.gate));
                    checkOutput("step_wrap", 32'(step_wrap), 32'(e.wrap));
                    checkOutput("pattern",   32'(pattern),   32'(e.pat));
                    if (step_wrap) wrap_count++;
                end
            end
        end
    end

    initial begin : driver
        int wraps_before;
        rst       = 1'b1;
        step_tick = 1'b0;
        tap_n     = 1'b1;
        rec_en    = 1'b0;
        overdub   = 1'b0;
        clear_all = 1'b0;
        length    = 5'd16;
        model_reset();
        #2 rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_pattern",   32'(pattern),   32'h0);
        checkOutput("rst_step_pos",  32'(step_pos),  32'h0);
        checkOutput("rst_gate_out",  32'(gate_out),  32'h0);
        checkOutput("rst_step_wrap", 32'(step_wrap), 32'h0);
        checkOutput("rst_tap_seen",  32'(tap_seen),  32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] debounce");
        rec_en  = 1'b1;
        overdub = 1'b1;
        start_tap(3);
        repeat (12) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        start_tap(10);
        repeat (20) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("debounce_pattern", 32'(pattern), 32'h0000_0002);
        applyStimulus(1'b0, 1'b1);
        rec_en = 1'b0;
        advance_to(0);

        $display("[TB] record 1111");
        rec_en     = 1'b1;
        overdub    = 1'b1;
        wraps_before = wrap_count;
        for (int s = 0; s < STEPS; s++) do_step((s % 4 == 0) ? 0 : -1, 4, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("record_pattern", 32'(pattern), 32'h0000_1111);
        checkOutput("record_wraps", 32'(wrap_count - wraps_before), 32'd1);

        $display("[TB] playback");
        rec_en       = 1'b0;
        wraps_before = wrap_count;
        for (int s = 0; s < STEPS; s++) begin
            checkOutput("play_step_pos", 32'(step_pos), 32'(s));
            checkOutput("play_gate_out", 32'(gate_out), 32'((s % 4) == 0));
            do_step(-1, 0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("play_pattern", 32'(pattern), 32'h0000_1111);
        checkOutput("play_wraps", 32'(wrap_count - wraps_before), 32'd1);

        $display("[TB] asynchronous reset");
        fill_all();
        do_step(-1, 0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pre_rst_gate_out", 32'(gate_out), 32'h1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_pattern",  32'(pattern),  32'h0);
        checkOutput("async_step_pos", 32'(step_pos), 32'h0);
        checkOutput("async_gate_out", 32'(gate_out), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_pattern",  32'(pattern),  32'h0);
        checkOutput("hold_step_pos", 32'(step_pos), 32'h0);
        checkOutput("hold_tap_seen", 32'(tap_seen), 32'h0);
        rst = 1'b1;
        model_reset();
        exp_q.delete();

        $display("[TB] replace mode");
        fill_all();
        overdub = 1'b0;
        for (int s = 0; s < STEPS; s++) do_step(-1, 0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("replace_empty", 32'(pattern), 32'h0);
        for (int s = 0; s < STEPS; s++) do_step((s == 3) ? 0 : -1, 4, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("replace_step3", 32'(pattern), 32'h0000_0008);

        $display("[TB] press on tick");
        overdub = 1'b1;
        applyStimulus(1'b0, 1'b1);
        for (int s = 0; s < 5; s++) do_step(-1, 0, 1'b0);
        do_step(5, 4, 1'b0);
        do_step(-1, 0, 1'b0);
        checkOutput("press_tick_pattern", 32'(pattern), 32'h0000_0040);
        do_step(-1, 0, 1'b0);

        $display("[TB] clear on tick");
        do_step(0, 4, 1'b1);
        checkOutput("clear_tick_pattern", 32'(pattern), 32'h0);
        checkOutput("clear_tick_pos", 32'(step_pos), 32'd9);

        $display("[TB] loop length");
        rec_en = 1'b0;
        do_step(-1, 0, 1'b0);
        length = 5'd4;
        applyStimulus(1'b1, 1'b0);
        checkOutput("shrink_pos",  32'(step_pos),  32'h0);
        checkOutput("shrink_wrap", 32'(step_wrap), 32'h1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0);
            checkOutput("len4_pos", 32'(step_pos), 32'((i + 1) % 4));
        end
        length = 5'd0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0);
            checkOutput("len0_pos", 32'(step_pos), 32'((i + 1) % 16));
        end

        $display("[TB] random traffic");
        rec_en = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(19, 0) == 0) rec_en  = ~rec_en;
            if ($urandom_range(19, 0) == 0) overdub = ~overdub;
            if ($urandom_range(39, 0) == 0) length  = 5'($urandom_range(20, 0));
            if (tap_idle() && $urandom_range(9, 0) == 0) start_tap(int'($urandom_range(10, 1)));
            applyStimulus($urandom_range(2, 0) == 0, $urandom_range(49, 0) == 0);
        end

        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gate_recorder.md
Name: gate_recorder

Overview:
- Writer side of the gate-loop path: captures live button taps, quantizes them to sequencer steps and stores them in a STEPS-bit loop pattern.
- Plays the stored pattern back as a step gate that gates an oscillator into pwmout, the same way the loop register's gate does.
- Sits between the board buttons and the oscillator gate in top; the step strobe comes from the top-level free-running counter.

Parameters:
- STEPS, 16, pattern length in steps (power of two, 2..64)
- DEBOUNCE, 65536, clk cycles the synchronized input must stay at a new level before the debounced state changes
- POS_W, $clog2(STEPS), width of the step index

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- step_tick  in  1  single-cycle strobe, one per step, synchronous to clk
- tap_n  in  1  raw button, active-low, asynchronous
- rec_en  in  1  1 = recording armed
- overdub  in  1  1 = OR new taps into the pattern; 0 = replace the pattern bit
- clear_all  in  1  synchronous pulse: pattern <= 0
- length  in  POS_W+1  active loop length, 1..STEPS; 0 is treated as STEPS
- gate_out  out  1  pattern bit at the current step
- step_pos  out  POS_W  current step index
- step_wrap  out  1  one-cycle pulse when step_pos returns to 0
- pattern  out  STEPS  full stored pattern
- tap_seen  out  1  debounced tap level (for LED)

Behaviour:
- Reset (rst low, asynchronous): pattern=0, step_pos=0, pending=0, sync flops=1 (idle), debounced=released, debounce counter=0, step_wrap=0, tap_seen=0.
- Synchronizer: 2 flops on tap_n. The inverted synced value is tap_level.
- Debounce: the counter increments while tap_level != debounced state and resets to 0 when they are equal. When the counter reaches DEBOUNCE-1, debounced <= tap_level and the counter <= 0. tap_seen = debounced.
- press = rising edge of debounced. Latency from a tap_n fall to press is 2 + DEBOUNCE cycles.
- pending flag:
  - set on press when rec_en=1.
  - cleared on step_tick.
  - press and step_tick in the same cycle: pending <= 1, so the tap belongs to the step being entered.
- On step_tick with rec_en=1:
  - overdub=1: pattern[step_pos] <= pattern[step_pos] | pending.
  - overdub=0: pattern[step_pos] <= pending.
  - The write uses the step being left, with the pending value from before the tick.
- On step_tick with rec_en=0: pattern is unchanged.
- Step advance on step_tick:
  - if step_pos >= eff_len-1, step_pos <= 0 and step_wrap pulses the next cycle; otherwise step_pos <= step_pos+1.
  - eff_len = (length==0 || length>STEPS) ? STEPS : length.
  - A length reduced below step_pos wraps to 0 on the next tick.
- clear_all has priority over a same-cycle step_tick write: pattern <= 0, while step_pos still advances.
- gate_out = pattern[step_pos], registered-free combinational read of registered state. It updates the cycle after a step_tick or write.
- rec_en dropping mid-step discards pending at the next tick, without a write.
- No handshake; step_tick is assumed ≤1 per 2 clk cycles. Back-to-back ticks are still legal and must advance each cycle.

Decomposition:
- Shared package/include holds:
  - the POS_W computation
  - the default DEBOUNCE constant
  - an ACTIVE_LOW button-inversion macro, reused by top for the other buttons.
- One natural sub-module: button_debounce (synchronizer + counter + rising-edge pulse, parameter DEBOUNCE). gate_recorder instantiates it once; top may reuse it for set/clear buttons.

Test Plan:
- Reset: hold rst=0 mid-run with pattern=16'hFFFF → pattern=0, step_pos=0, gate_out=0 immediately (asynchronous), all stable until rst=1.
- Debounce: DEBOUNCE=4; tap_n low for 3 cycles then high → no press. Low for 10 cycles → tap_seen rises exactly 6 cycles after the fall, pending=1.
- Record/playback, STEPS=16, length=16, overdub=1, rec_en=1: tap during steps 0,4,8,12 → pattern=16'h1111. Next loop, rec_en=0 → gate_out high only at step_pos 0,4,8,12; step_wrap pulses once per 16 ticks.
- Replace mode: pattern=16'hFFFF, overdub=0, rec_en=1, no taps for one full loop → pattern=0. Tap only at step 3 → pattern=16'h0008.
- Boundary:
  - press in the same cycle as the tick leaving step 5 → bit 6 set, bit 5 unchanged.
  - clear_all coincident with a tick-write → pattern=0, step_pos advances.
- Length: at step_pos=10, set length=4 → next tick step_pos=0 with step_wrap. After that, step_pos cycles 0..3. length=0 → cycles 0..15.
